// File: rtl/crossing_tracker.sv
// Debounced line-crossing detector: counts each all-black sensor event exactly once,
// with wrap/saturate counter, sticky overflow and an optional stuck-on-line watchdog.
module crossing_tracker #(
   parameter int unsigned NUM_SENSORS = 3,
   parameter int unsigned COUNT_W     = 2,
   parameter int unsigned START_COUNT = 1,
   parameter int unsigned DEBOUNCE    = 1,
   parameter bit          SATURATE    = 1'b0,
   parameter int unsigned STUCK_LIMIT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   reset_station,
   input  logic                   reset_crossing_counter,
   input  logic [NUM_SENSORS-1:0] sensor,
   input  logic [COUNT_W-1:0]     target,
   output logic [COUNT_W-1:0]     crossing_counter,
   output logic                   crossing_pulse,
   output logic                   on_crossing,
   output logic                   target_reached,
   output logic                   overflow,
   output logic                   stuck
);

   localparam int unsigned DebW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam int unsigned StkW = (STUCK_LIMIT > 0) ? $clog2(STUCK_LIMIT + 1) : 1;
   localparam logic [DebW:0]        DebTarget = (DebW + 1)'(DEBOUNCE);
   localparam logic [DebW:0]        DebOne    = 1;
   localparam logic [DebW-1:0]      DebInit   = 1;
   localparam logic [StkW-1:0]      StkLimit  = StkW'(STUCK_LIMIT);
   localparam logic [StkW-1:0]      StkOne    = 1;
   localparam logic [COUNT_W-1:0]   StartVal  = COUNT_W'(START_COUNT);
   localparam logic [COUNT_W-1:0]   CountMax  = '1;
   localparam logic [COUNT_W-1:0]   CntOne    = 1;

   typedef enum logic [2:0] {StIdle, StArm, StCount, StOnLine, StExit} state_e;

   state_e              state_q, state_d;
   logic [DebW-1:0]     deb_q, deb_d;
   logic [DebW:0]       deb_inc;
   logic [StkW-1:0]     stk_q, stk_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                pulse_q, on_q, stuck_q;
   logic                zero, inc, stuck_d, on_d;

   assign zero    = ~|sensor;
   assign deb_inc = {1'b0, deb_q} + DebOne;
   assign inc     = enable && (state_q == StCount);

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      if (!enable) begin
         state_d = StIdle;
         deb_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (zero) begin
                  state_d = (DEBOUNCE == 1) ? StCount : StArm;
                  deb_d   = (DEBOUNCE == 1) ? '0 : DebInit;
               end
            end
            StArm: begin
               if (!zero) begin
                  state_d = StIdle;
                  deb_d   = '0;
               end else if (deb_inc >= DebTarget) begin
                  state_d = StCount;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_inc[DebW-1:0];
               end
            end
            StCount: begin
               state_d = StOnLine;
               deb_d   = '0;
            end
            StOnLine: begin
               if (!zero) begin
                  state_d = (DEBOUNCE == 1) ? StIdle : StExit;
                  deb_d   = (DEBOUNCE == 1) ? '0 : DebInit;
               end
            end
            StExit: begin
               if (zero) begin
                  // Re-entry during exit resumes the same crossing; never recounts.
                  state_d = StOnLine;
                  deb_d   = '0;
               end else if (deb_inc >= DebTarget) begin
                  state_d = StIdle;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_inc[DebW-1:0];
               end
            end
            default: begin
               state_d = StIdle;
               deb_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stk_d = stk_q;
      if (!enable || state_d == StIdle) begin
         stk_d = '0;
      end else if ((state_q == StOnLine || state_q == StExit) && stk_q != StkLimit) begin
         stk_d = stk_q + StkOne;
      end
   end

   assign stuck_d = (STUCK_LIMIT != 0) && (stk_d == StkLimit);
   assign on_d    = (state_d == StOnLine) || (state_d == StExit);

   // Clears outrank the increment; a lost increment still produces its pulse.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (reset_station) begin
         cnt_d = StartVal;
         ovf_d = 1'b0;
      end else if (reset_crossing_counter) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (cnt_q == CountMax) begin
            ovf_d = 1'b1;
            if (!SATURATE) cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         deb_q   <= '0;
         stk_q   <= '0;
         cnt_q   <= StartVal;
         ovf_q   <= 1'b0;
         pulse_q <= 1'b0;
         on_q    <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         stk_q   <= stk_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         pulse_q <= inc;
         on_q    <= on_d;
         stuck_q <= stuck_d;
      end
   end

   assign crossing_counter = cnt_q;
   assign crossing_pulse   = pulse_q;
   assign on_crossing      = on_q;
   assign overflow         = ovf_q;
   assign stuck            = stuck_q;
   assign target_reached   = (cnt_q == target);

endmodule
